tensor_core_matrix_buffer: RTL and testbench
============================================

# tensor_core_matrix_buffer

Parametrised, double-buffered operand store for the tensor core. It holds two complete banks of `NUM_MATRICES` square matrices. The tensor core reads the *active* bank in bulk every cycle and writes results back into it. Meanwhile the *shadow* bank is filled element by element over a valid/ready stream. A swap handshake exchanges the banks in one clock, so the tensor core never stalls on operand loading.

## Interface
Parameters:
- `DATA_WIDTH`, 8: signed element width.
- `MATRIX_SIZE`, 3: N, matrices are N×N.
- `NUM_MATRICES`, 2: M, matrices per bank.
- Derived: `TOTAL = M*N*N`; `ADDR_W = $clog2(TOTAL)`.

Ports:
- `clock_in`, in, 1: the single clock.
- `reset_in`, in, 1: asynchronous, active-low reset.
- `stream_valid_in`, in, 1: stream element valid.
- `stream_data_in`, in, DATA_WIDTH: signed stream element.
- `stream_ready_out`, out, 1: shadow bank accepting elements.
- `shadow_full_out`, out, 1: shadow bank completely loaded.
- `swap_request_in`, in, 1: level request to exchange banks.
- `swap_ack_out`, out, 1: one-cycle pulse, swap performed.
- `result_write_enable_in`, in, 1: write one result matrix into the active bank.
- `result_matrix_index_in`, in, $clog2(M) (min 1): target matrix for the result write.
- `result_data_in`, in, [N][N]×DATA_WIDTH: signed result matrix.
- `active_data_out`, out, [M][N][N]×DATA_WIDTH: combinational view of the active bank.
- `read_address_in`, in, ADDR_W: single-element debug/host read address.
- `read_data_out`, out, DATA_WIDTH: registered single-element read.

## Operation
- **Element index:** `idx = m*N*N + r*N + c`. Streaming order is matrix-major, then row-major.
- **Storage:** two banks. `bank_sel` selects the active bank; `!bank_sel` is the shadow bank.
- **Load FSM states:**
  - FILLING: `stream_ready_out=1`. Each `valid&&ready` cycle writes `stream_data_in` to shadow[`load_count`], then `load_count++`. Accepting at `load_count==TOTAL-1` moves to FULL and wraps `load_count` to 0.
  - FULL: `stream_ready_out=0`, `shadow_full_out=1`. Stream input is ignored.
- **Swap:** taken on a clock edge when all three hold: state==FULL, `swap_request_in`=1, `result_write_enable_in`=0.
  - Effect: toggle `bank_sel`, go to FILLING, pulse `swap_ack_out` in the following cycle.
  - A request in FILLING is held pending with no ack and no error. The requester keeps the level high until it sees the ack.
  - While the ack is high the state is FILLING, so a still-high request cannot cause a double swap.
- **Result write:** overwrites active[`result_matrix_index_in`][*][*] with `result_data_in`.
  - Has priority over swap: a same-cycle swap is deferred by one or more cycles.
  - An index ≥ M is ignored.
- **Stream vs result writes:** these target different banks and never conflict; both apply in the same cycle.
- **Debug read:** `read_data_out` ← active[`read_address_in`] on each edge. An address ≥ TOTAL returns 0.
- **Arithmetic:** no arithmetic on data. Values are stored bit-exact; widths always match `DATA_WIDTH`.

## Timing
- **Reset** (async assert, synchronous deassert handled upstream):
  - Both banks all 0; `bank_sel`=0; state FILLING; `load_count`=0.
  - Outputs: `stream_ready_out`=1, `shadow_full_out`=0, `swap_ack_out`=0, `read_data_out`=0, `active_data_out` all 0.
- **Reset mid-load or mid-swap:** all progress is discarded and the state returns to the reset state. No partial-swap state exists.
- **Stream:** one element per cycle maximum. `ready` does not depend on `valid`. `shadow_full_out` rises in the cycle after the last accept.
- **Swap:**
  - Request to swap edge: 0 cycles when FULL and no result write is pending.
  - `active_data_out` shows the new bank in the cycle after the swap edge, together with `swap_ack_out`.
  - `stream_ready_out` is 1 in that same cycle.
- **Result write:** visible on `active_data_out` in the next cycle.
- **Debug read:** latency is 1 cycle and reflects active-bank contents as of the previous edge.

## Structure
- Shared `tensor_core_pkg` contains:
  - Default `DATA_WIDTH` / `MATRIX_SIZE` / `NUM_MATRICES`.
  - `load_state_t` enum {FILLING, FULL}.
  - An index-decode function from a flat index to (m, r, c).
- Sub-module `tensor_core_load_sequencer` contains the FSM, `load_count`, the swap arbitration and `swap_ack_out` generation. It outputs a write strobe and index for the shadow bank. Storage and the read muxes stay in the top module.

## Test plan
- **Reset:** assert `reset_in`=0 mid-stream after 5 accepts → all outputs at reset values immediately. After release, the first accepted element lands at shadow idx 0.
- **Fill and swap:** stream values 1..18 continuously, hold `swap_request_in`=1 → `shadow_full_out` rises after the 18th accept. `swap_ack_out` pulses once, then `active_data_out[1][2][2]`=18 and `[0][0][1]`=2.
- **Backpressure:** after 18 accepts, keep `valid` high with value 99 → `stream_ready_out`=0 and no bank changes. Swap, then the first accept writes 99 at idx 0 of the new shadow bank.
- **Early swap:** request swap after 10 accepts → no ack for 8 more accepts. The ack arrives on the cycle after `load_count` wraps.
- **Priority:** write a result of all −5 to matrix 1 with a same-cycle swap request while FULL → swap deferred one cycle. The old active matrix 1 reads −5 via debug read at idx 9 before the ack.
- **Debug read bounds:** address 17 → last element of the active bank. Address 31 (ADDR_W=5) → 0.

Source files
------------

// File: rtl/tensor_core_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tensor_core_pkg : shared defaults, load-state encoding and flat-index decode
// Rev 1.0
// ----------------------------------------------------------------------------
package tensor_core_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_MATRIX_SIZE  = 3;
  localparam int DEFAULT_NUM_MATRICES = 2;

  typedef enum logic [0:0] {
    FILLING = 1'b0,
    FULL    = 1'b1
  } load_state_t;

  typedef struct packed {
    logic [31:0] m;
    logic [31:0] r;
    logic [31:0] c;
  } elem_pos_t;

  // Flat index is matrix-major, then row-major: idx = m*N*N + r*N + c
  function automatic elem_pos_t decode_index(input int unsigned idx, input int unsigned n);
    elem_pos_t pos;
    pos.m = 32'(idx / (n * n));
    pos.r = 32'((idx % (n * n)) / n);
    pos.c = 32'(idx % n);
    return pos;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tensor_core_load_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tensor_core_load_sequencer : shadow-bank fill FSM, swap arbitration and ack
// Rev 1.0
// ----------------------------------------------------------------------------
module tensor_core_load_sequencer
  import tensor_core_pkg::*;
#(
  parameter int TOTAL  = 18,
  parameter int ADDR_W = $clog2(TOTAL)
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              stream_valid_in,
  input  logic              swap_request_in,
  input  logic              result_write_enable_in,
  output logic              stream_ready_out,
  output logic              shadow_full_out,
  output logic              swap_ack_out,
  output logic              bank_sel,
  output logic              shadow_write,
  output logic [ADDR_W-1:0] shadow_index
);

  load_state_t       state;
  load_state_t       state_next;
  logic [ADDR_W-1:0] load_count;
  logic [ADDR_W-1:0] load_count_next;
  logic              bank_sel_next;
  logic              swap_take;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state        <= FILLING;
      load_count   <= '0;
      bank_sel     <= 1'b0;
      swap_ack_out <= 1'b0;
    end else begin
      state        <= state_next;
      load_count   <= load_count_next;
      bank_sel     <= bank_sel_next;
      swap_ack_out <= swap_take;
    end
  end

  // A result write into the active bank defers the swap so it never lands in the shadow
  always_comb begin
    state_next      = state;
    load_count_next = load_count;
    bank_sel_next   = bank_sel;
    swap_take       = 1'b0;
    case (state)
      FILLING: begin
        if (stream_valid_in) begin
          if (load_count == ADDR_W'(TOTAL - 1)) begin
            load_count_next = '0;
            state_next      = FULL;
          end else begin
            load_count_next = load_count + 1'b1;
          end
        end
      end
      FULL: begin
        if (swap_request_in && !result_write_enable_in) begin
          swap_take     = 1'b1;
          bank_sel_next = ~bank_sel;
          state_next    = FILLING;
        end
      end
      default: state_next = FILLING;
    endcase
  end

  always_comb begin
    stream_ready_out = (state == FILLING);
    shadow_full_out  = (state == FULL);
    shadow_write     = (state == FILLING) && stream_valid_in;
    shadow_index     = load_count;
  end

endmodule
`default_nettype wire

// File: rtl/tensor_core_matrix_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tensor_core_matrix_buffer : double-buffered operand store with bank swap
// Rev 1.0
// ----------------------------------------------------------------------------
module tensor_core_matrix_buffer
  import tensor_core_pkg::*;
#(
  parameter  int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter  int MATRIX_SIZE  = DEFAULT_MATRIX_SIZE,
  parameter  int NUM_MATRICES = DEFAULT_NUM_MATRICES,
  localparam int TOTAL        = NUM_MATRICES * MATRIX_SIZE * MATRIX_SIZE,
  localparam int ADDR_W       = $clog2(TOTAL),
  localparam int IDX_W        = (NUM_MATRICES > 1) ? $clog2(NUM_MATRICES) : 1
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     stream_valid_in,
  input  logic signed [DATA_WIDTH-1:0] stream_data_in,
  output logic                     stream_ready_out,
  output logic                     shadow_full_out,
  input  logic                     swap_request_in,
  output logic                     swap_ack_out,
  input  logic                     result_write_enable_in,
  input  logic [IDX_W-1:0]         result_matrix_index_in,
  input  logic signed [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0] result_data_in,
  output logic signed [NUM_MATRICES-1:0][MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0] active_data_out,
  input  logic [ADDR_W-1:0]        read_address_in,
  output logic signed [DATA_WIDTH-1:0] read_data_out
);

  logic [DATA_WIDTH-1:0] bank [2][TOTAL];
  logic                  bank_sel;
  logic                  shadow_write;
  logic [ADDR_W-1:0]     shadow_index;
  logic [TOTAL-1:0]      result_hit;
  logic [DATA_WIDTH-1:0] result_elem [TOTAL];

  tensor_core_load_sequencer #(
    .TOTAL  (TOTAL),
    .ADDR_W (ADDR_W)
  ) u_sequencer (
    .clock_in               (clock_in),
    .reset_in               (reset_in),
    .stream_valid_in        (stream_valid_in),
    .swap_request_in        (swap_request_in),
    .result_write_enable_in (result_write_enable_in),
    .stream_ready_out       (stream_ready_out),
    .shadow_full_out        (shadow_full_out),
    .swap_ack_out           (swap_ack_out),
    .bank_sel               (bank_sel),
    .shadow_write           (shadow_write),
    .shadow_index           (shadow_index)
  );

  // Per-element wiring; an out-of-range matrix index never matches any element
  for (genvar i = 0; i < TOTAL; i++) begin : g_elem
    localparam elem_pos_t POS = decode_index(i, MATRIX_SIZE);
    assign result_hit[i]  = result_write_enable_in && (32'(result_matrix_index_in) == POS.m);
    assign result_elem[i] = result_data_in[POS.r][POS.c];
    assign active_data_out[POS.m][POS.r][POS.c] = bank[bank_sel][i];
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < TOTAL; i++) begin
          bank[b][i] <= '0;
        end
      end
      read_data_out <= '0;
    end else begin
      if (shadow_write) begin
        bank[~bank_sel][shadow_index] <= stream_data_in;
      end
      for (int i = 0; i < TOTAL; i++) begin
        if (result_hit[i]) begin
          bank[bank_sel][i] <= result_elem[i];
        end
      end
      if ({1'b0, read_address_in} < (ADDR_W + 1)'(TOTAL)) begin
        read_data_out <= bank[bank_sel][read_address_in];
      end else begin
        read_data_out <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tensor_core_matrix_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tensor_core_matrix_buffer : self-checking bench against a bank-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_tensor_core_matrix_buffer;

  localparam int DW    = 8;
  localparam int N     = 3;
  localparam int M     = 2;
  localparam int TOTAL = M * N * N;
  localparam int AW    = 5;
  localparam int VW    = M * N * N * DW;

  logic clock_in = 1'b0;
  logic reset_in = 1'b0;
  logic stream_valid_in = 1'b0;
  logic signed [DW-1:0] stream_data_in = '0;
  logic stream_ready_out;
  logic shadow_full_out;
  logic swap_request_in = 1'b0;
  logic swap_ack_out;
  logic result_write_enable_in = 1'b0;
  logic [0:0] result_matrix_index_in = '0;
  logic signed [N-1:0][N-1:0][DW-1:0] result_data_in = '0;
  logic signed [M-1:0][N-1:0][N-1:0][DW-1:0] active_data_out;
  logic [AW-1:0] read_address_in = '0;
  logic signed [DW-1:0] read_data_out;

  always #5 clock_in = ~clock_in;

  tensor_core_matrix_buffer dut (
    .clock_in               (clock_in),
    .reset_in               (reset_in),
    .stream_valid_in        (stream_valid_in),
    .stream_data_in         (stream_data_in),
    .stream_ready_out       (stream_ready_out),
    .shadow_full_out        (shadow_full_out),
    .swap_request_in        (swap_request_in),
    .swap_ack_out           (swap_ack_out),
    .result_write_enable_in (result_write_enable_in),
    .result_matrix_index_in (result_matrix_index_in),
    .result_data_in         (result_data_in),
    .active_data_out        (active_data_out),
    .read_address_in        (read_address_in),
    .read_data_out          (read_data_out)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: two banks of flat elements, which one is active, how many loaded
  logic [DW-1:0] mb [2][TOTAL];
  int            msel;
  int            mloaded;
  bit            mfull;
  bit            mack;
  logic [DW-1:0] mread;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] expv;
    string         name;
  } dbg_vec_t;
  dbg_vec_t tbl [6];

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < TOTAL; i++) mb[b][i] = '0;
    msel = 0; mloaded = 0; mfull = 0; mack = 0; mread = '0;
  endfunction

  function automatic void model_edge();
    bit swap;
    if (!reset_in) begin
      model_reset();
      return;
    end
    mread = (read_address_in < TOTAL) ? mb[msel][read_address_in] : '0;
    swap  = mfull && swap_request_in && !result_write_enable_in;
    if (!mfull && stream_valid_in) begin
      mb[1-msel][mloaded] = stream_data_in;
      mloaded++;
      if (mloaded == TOTAL) begin
        mfull = 1; mloaded = 0;
      end
    end
    if (result_write_enable_in && result_matrix_index_in < M)
      for (int k = 0; k < N*N; k++)
        mb[msel][result_matrix_index_in*N*N + k] = result_data_in[k/N][k%N];
    mack = swap;
    if (swap) begin
      msel = 1 - msel; mfull = 0;
    end
  endfunction

  function automatic logic [VW-1:0] exp_active();
    logic [VW-1:0] v;
    for (int i = 0; i < TOTAL; i++) v[i*DW +: DW] = mb[msel][i];
    return v;
  endfunction

  task automatic compare_all();
    check("ready",  VW'(stream_ready_out), VW'(!mfull));
    check("full",   VW'(shadow_full_out),  VW'(mfull));
    check("ack",    VW'(swap_ack_out),     VW'(mack));
    check("read",   VW'($unsigned(read_data_out)), VW'(mread));
    check("active", $unsigned(active_data_out), exp_active());
  endtask

  task automatic step();
    @(posedge clock_in);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int edges;
    bit got;
    tbl[0] = '{5'd0,  8'd99,  "dbg_idx0"};
    tbl[1] = '{5'd1,  8'd101, "dbg_idx1"};
    tbl[2] = '{5'd9,  8'd109, "dbg_idx9"};
    tbl[3] = '{5'd17, 8'd117, "dbg_last"};
    tbl[4] = '{5'd18, 8'd0,   "dbg_oob18"};
    tbl[5] = '{5'd31, 8'd0,   "dbg_oob31"};

    model_reset();
    repeat (2) step();
    check("rst_ready", VW'(stream_ready_out), VW'(1));
    check("rst_active", $unsigned(active_data_out), '0);
    reset_in = 1'b1;

    // Reset in the middle of a load discards the partial fill
    stream_valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stream_data_in = DW'(50 + i);
      step();
    end
    #2 reset_in = 1'b0;
    #1 model_reset();
    compare_all();
    check("async_rst_ready", VW'(stream_ready_out), VW'(1));
    stream_valid_in = 1'b0;
    step();
    reset_in = 1'b1;

    // Fill with 1..18 while a swap request is already held
    swap_request_in = 1'b1;
    stream_valid_in = 1'b1;
    for (int i = 1; i <= TOTAL; i++) begin
      stream_data_in = DW'(i);
      step();
    end
    stream_valid_in = 1'b0;
    check("fill_full", VW'(shadow_full_out), VW'(1));
    step();
    check("fill_ack", VW'(swap_ack_out), VW'(1));
    check("fill_m1r2c2", VW'($unsigned(active_data_out[1][2][2])), VW'(18));
    check("fill_m0r0c1", VW'($unsigned(active_data_out[0][0][1])), VW'(2));
    swap_request_in = 1'b0;
    step();
    check("ack_single", VW'(swap_ack_out), VW'(0));

    // Backpressure: stream held valid while full must not disturb anything
    stream_valid_in = 1'b1;
    for (int i = 0; i < TOTAL; i++) begin
      stream_data_in = DW'(20 + i);
      step();
    end
    stream_data_in = DW'(99);
    repeat (3) begin
      step();
      check("bp_ready", VW'(stream_ready_out), VW'(0));
    end
    swap_request_in = 1'b1;
    step();
    swap_request_in = 1'b0;
    step();
    for (int i = 1; i < TOTAL; i++) begin
      stream_data_in = DW'(100 + i);
      step();
    end
    stream_valid_in = 1'b0;
    swap_request_in = 1'b1;
    step();
    swap_request_in = 1'b0;
    step();

    for (int t = 0; t < 6; t++) begin
      read_address_in = tbl[t].addr;
      step();
      check(tbl[t].name, VW'($unsigned(read_data_out)), VW'(tbl[t].expv));
    end

    // Early swap request is held until the bank completes
    stream_valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stream_data_in = DW'($urandom);
      step();
    end
    swap_request_in = 1'b1;
    edges = 0;
    got   = 0;
    while (!got && edges < 30) begin
      stream_data_in = DW'($urandom);
      step();
      edges++;
      if (swap_ack_out) got = 1;
    end
    check("early_ack_edges", VW'(edges), VW'(9));
    swap_request_in = 1'b0;
    stream_valid_in = 1'b0;
    step();

    // Result write has priority over a same-cycle swap
    stream_valid_in = 1'b1;
    for (int i = 0; i < TOTAL; i++) begin
      stream_data_in = DW'($urandom);
      step();
    end
    stream_valid_in = 1'b0;
    read_address_in = 5'd9;
    result_write_enable_in = 1'b1;
    result_matrix_index_in = 1'b1;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) result_data_in[r][c] = -8'sd5;
    swap_request_in = 1'b1;
    step();
    check("prio_deferred", VW'(swap_ack_out), VW'(0));
    result_write_enable_in = 1'b0;
    step();
    check("prio_ack", VW'(swap_ack_out), VW'(1));
    check("prio_read", VW'($unsigned(read_data_out)), VW'(8'hFB));
    swap_request_in = 1'b0;
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      stream_valid_in        = ($urandom_range(0, 3) != 0);
      stream_data_in         = DW'($urandom);
      swap_request_in        = ($urandom_range(0, 2) == 0);
      result_write_enable_in = ($urandom_range(0, 5) == 0);
      result_matrix_index_in = 1'($urandom_range(0, 1));
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) result_data_in[r][c] = DW'($urandom);
      read_address_in        = AW'($urandom_range(0, 31));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
